// File: rtl/coin_change_dispenser_if.sv
// +----------------------------------------------------------------------+
// | coin_change_dispenser_if: coin-ejector valid/ready handshake bundle   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface coin_change_dispenser_if;
  logic       dispenseValid;
  logic [1:0] dispense;
  logic       dispenseReady;

  modport master (output dispenseValid, output dispense, input dispenseReady);
  modport slave  (input dispenseValid, input dispense, output dispenseReady);
endinterface

`default_nettype wire

// File: rtl/coin_change_dispenser.sv
// +----------------------------------------------------------------------+
// | coin_change_dispenser: coin inventory, credit and greedy change payout|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module coin_change_dispenser #(
  parameter logic [7:0] INIT_NICKELS  = 8'd5,
  parameter logic [7:0] INIT_DIMES    = 8'd5,
  parameter logic [7:0] INIT_QUARTERS = 8'd5
) (
  input  wire logic               clock,
  input  wire logic               reset,
  input  wire logic               coinValid,
  input  wire logic [1:0]         coinType,
  input  wire logic               vend,
  input  wire logic [7:0]         price,
  coin_change_dispenser_if.master disp,
  output logic      [7:0]         credit,
  output logic      [7:0]         nickelCount,
  output logic      [7:0]         dimeCount,
  output logic      [7:0]         quarterCount,
  output logic                    coinReject,
  output logic                    vendOk,
  output logic                    vendFail,
  output logic                    busy
);

  typedef enum logic [1:0] {S_IDLE, S_PLAN, S_DISPENSE} state_t;

  state_t     state;
  logic [7:0] rem;
  logic [7:0] avail_n, avail_d, avail_q;
  logic [7:0] plan_n, plan_d, plan_q;

  logic [7:0] coin_val;
  logic       cnt_full;
  logic [8:0] coin_sum;
  logic       coin_ok;
  logic [7:0] credit_eff, nick_eff, dime_eff, quar_eff;
  logic [7:0] pn_next, pd_next, pq_next;
  logic       plan_any;

  // Coin in the same cycle as vend is folded in first, so vend sees *_eff.
  always_comb begin
    coin_val = 8'd0;
    cnt_full = 1'b1;
    case (coinType)
      2'b01: begin coin_val = 8'd5;  cnt_full = (nickelCount  == 8'hFF); end
      2'b10: begin coin_val = 8'd10; cnt_full = (dimeCount    == 8'hFF); end
      2'b11: begin coin_val = 8'd25; cnt_full = (quarterCount == 8'hFF); end
      default: ;
    endcase
    coin_sum   = {1'b0, credit} + {1'b0, coin_val};
    coin_ok    = coinValid && (coinType != 2'b00) && !coin_sum[8] && !cnt_full;
    credit_eff = coin_ok ? coin_sum[7:0] : credit;
    nick_eff   = nickelCount  + {7'd0, coin_ok && (coinType == 2'b01)};
    dime_eff   = dimeCount    + {7'd0, coin_ok && (coinType == 2'b10)};
    quar_eff   = quarterCount + {7'd0, coin_ok && (coinType == 2'b11)};
    pq_next    = plan_q - {7'd0, disp.dispense == 2'b11};
    pd_next    = plan_d - {7'd0, disp.dispense == 2'b10};
    pn_next    = plan_n - {7'd0, disp.dispense == 2'b01};
    plan_any   = (plan_q != 8'd0) || (plan_d != 8'd0) || (plan_n != 8'd0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= S_IDLE;
      credit             <= 8'd0;
      nickelCount        <= INIT_NICKELS;
      dimeCount          <= INIT_DIMES;
      quarterCount       <= INIT_QUARTERS;
      rem                <= 8'd0;
      avail_n            <= 8'd0;
      avail_d            <= 8'd0;
      avail_q            <= 8'd0;
      plan_n             <= 8'd0;
      plan_d             <= 8'd0;
      plan_q             <= 8'd0;
      disp.dispenseValid <= 1'b0;
      disp.dispense      <= 2'b00;
      coinReject         <= 1'b0;
      vendOk             <= 1'b0;
      vendFail           <= 1'b0;
      busy               <= 1'b0;
    end else begin
      coinReject <= 1'b0;
      vendOk     <= 1'b0;
      vendFail   <= 1'b0;
      case (state)
        S_IDLE: begin
          coinReject   <= coinValid && !coin_ok;
          credit       <= credit_eff;
          nickelCount  <= nick_eff;
          dimeCount    <= dime_eff;
          quarterCount <= quar_eff;
          if (vend) begin
            if (credit_eff < price) begin
              vendFail <= 1'b1;
            end else begin
              rem     <= credit_eff - price;
              avail_n <= nick_eff;
              avail_d <= dime_eff;
              avail_q <= quar_eff;
              plan_n  <= 8'd0;
              plan_d  <= 8'd0;
              plan_q  <= 8'd0;
              state   <= S_PLAN;
              busy    <= 1'b1;
            end
          end
        end

        S_PLAN: begin
          coinReject <= coinValid;
          if (rem >= 8'd25 && avail_q != 8'd0) begin
            rem     <= rem - 8'd25;
            avail_q <= avail_q - 8'd1;
            plan_q  <= plan_q + 8'd1;
          end else if (rem >= 8'd10 && avail_d != 8'd0) begin
            rem     <= rem - 8'd10;
            avail_d <= avail_d - 8'd1;
            plan_d  <= plan_d + 8'd1;
          end else if (rem >= 8'd5 && avail_n != 8'd0) begin
            rem     <= rem - 8'd5;
            avail_n <= avail_n - 8'd1;
            plan_n  <= plan_n + 8'd1;
          end else if (rem == 8'd0 && plan_any) begin
            state              <= S_DISPENSE;
            disp.dispenseValid <= 1'b1;
            disp.dispense      <= (plan_q != 8'd0) ? 2'b11 :
                                  (plan_d != 8'd0) ? 2'b10 : 2'b01;
          end else if (rem == 8'd0) begin
            vendOk <= 1'b1;
            credit <= 8'd0;
            state  <= S_IDLE;
            busy   <= 1'b0;
          end else begin
            vendFail <= 1'b1;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end
        end

        S_DISPENSE: begin
          coinReject <= coinValid;
          if (disp.dispenseReady) begin
            quarterCount <= quarterCount - {7'd0, disp.dispense == 2'b11};
            dimeCount    <= dimeCount    - {7'd0, disp.dispense == 2'b10};
            nickelCount  <= nickelCount  - {7'd0, disp.dispense == 2'b01};
            plan_q       <= pq_next;
            plan_d       <= pd_next;
            plan_n       <= pn_next;
            if (pq_next == 8'd0 && pd_next == 8'd0 && pn_next == 8'd0) begin
              disp.dispenseValid <= 1'b0;
              disp.dispense      <= 2'b00;
              vendOk             <= 1'b1;
              credit             <= 8'd0;
              state              <= S_IDLE;
              busy               <= 1'b0;
            end else begin
              disp.dispense <= (pq_next != 8'd0) ? 2'b11 :
                               (pd_next != 8'd0) ? 2'b10 : 2'b01;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_coin_change_dispenser.sv
// +----------------------------------------------------------------------+
// | tb_coin_change_dispenser: scoreboard bench with transaction-level model|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_coin_change_dispenser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       vend = 1'b0;
  logic [7:0] price = 8'd0;
  logic [7:0] credit, n_cnt, d_cnt, q_cnt;
  logic       coin_reject, vend_ok, vend_fail, busy;

  coin_change_dispenser_if dif ();

  coin_change_dispenser dut (
    .clock(clk), .reset(rst), .coinValid(coin_valid), .coinType(coin_type),
    .vend(vend), .price(price), .disp(dif.master), .credit(credit),
    .nickelCount(n_cnt), .dimeCount(d_cnt), .quarterCount(q_cnt),
    .coinReject(coin_reject), .vendOk(vend_ok), .vendFail(vend_fail), .busy(busy)
  );

  logic       c2_valid = 1'b0;
  logic [1:0] c2_type = 2'b00;
  logic       c2_vend = 1'b0;
  logic [7:0] c2_price = 8'd0;
  logic [7:0] credit2, n2, d2, q2;
  logic       rej2, ok2, fail2, busy2;

  coin_change_dispenser_if if2 ();

  coin_change_dispenser #(.INIT_NICKELS(8'd0), .INIT_DIMES(8'd0), .INIT_QUARTERS(8'd5)) dut2 (
    .clock(clk), .reset(rst), .coinValid(c2_valid), .coinType(c2_type),
    .vend(c2_vend), .price(c2_price), .disp(if2.master), .credit(credit2),
    .nickelCount(n2), .dimeCount(d2), .quarterCount(q2),
    .coinReject(rej2), .vendOk(ok2), .vendFail(fail2), .busy(busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ok;
    int cr;
    int n;
    int d;
    int q;
  } res_t;

  res_t       q_res[$];
  logic [1:0] q_coin[$];
  int         q_rej[$];

  int total = 0;
  int bad   = 0;
  int m_cr, m_n, m_d, m_q;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: got unexpected DUT event, expected none at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_cr = 0; m_n = 5; m_d = 5; m_q = 5;
    q_res.delete(); q_coin.delete(); q_rej.delete();
  endtask

  task automatic model_coin(input logic [1:0] t);
    int v;
    int c;
    v = (t == 2'b01) ? 5 : (t == 2'b10) ? 10 : (t == 2'b11) ? 25 : 0;
    c = (t == 2'b01) ? m_n : (t == 2'b10) ? m_d : m_q;
    if (v == 0 || m_cr + v > 255 || c == 255) begin
      q_rej.push_back(m_cr);
    end else begin
      m_cr += v;
      if (t == 2'b01) m_n++;
      else if (t == 2'b10) m_d++;
      else m_q++;
    end
  endtask

  // Greedy change: take as many of each coin as fit, largest first.
  task automatic model_vend(input int p);
    int rem, nq, nd, nn;
    res_t r;
    if (p > m_cr) begin
      r = '{0, m_cr, m_n, m_d, m_q};
      q_res.push_back(r);
      return;
    end
    rem = m_cr - p;
    nq = (rem / 25 < m_q) ? rem / 25 : m_q;  rem -= 25 * nq;
    nd = (rem / 10 < m_d) ? rem / 10 : m_d;  rem -= 10 * nd;
    nn = (rem / 5  < m_n) ? rem / 5  : m_n;  rem -= 5 * nn;
    if (rem != 0) begin
      r = '{0, m_cr, m_n, m_d, m_q};
    end else begin
      repeat (nq) q_coin.push_back(2'b11);
      repeat (nd) q_coin.push_back(2'b10);
      repeat (nn) q_coin.push_back(2'b01);
      m_q -= nq; m_d -= nd; m_n -= nn; m_cr = 0;
      r = '{1, 0, m_n, m_d, m_q};
    end
    q_res.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [1:0] t);
    coin_valid = 1'b1; coin_type = t;
    model_coin(t);
    step();
    coin_valid = 1'b0; coin_type = 2'b00;
    chk("credit_after_coin", credit, m_cr);
  endtask

  task automatic wait_idle(input bit rnd);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (!busy) done = 1'b1;
      else begin
        if (rnd) dif.dispenseReady = 1'($urandom_range(0, 1));
        step();
      end
    end
    if (!done) flag("idle_timeout");
  endtask

  task automatic do_vend(input int p, input bit with_coin, input logic [1:0] t);
    vend = 1'b1; price = 8'(p);
    if (with_coin) begin
      coin_valid = 1'b1; coin_type = t;
      model_coin(t);
    end
    model_vend(p);
    step();
    vend = 1'b0; coin_valid = 1'b0; coin_type = 2'b00;
    wait_idle(1'b1);
  endtask

  task automatic monitor();
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (coin_reject) begin
          if (q_rej.size() == 0) flag("reject");
          else chk("reject_credit", credit, q_rej.pop_front());
        end
        if (vend_ok || vend_fail) begin
          if (q_res.size() == 0) flag("vend_result");
          else begin
            r = q_res.pop_front();
            chk("vend_ok", vend_ok, r.ok);
            chk("vend_fail", vend_fail, !r.ok);
            chk("result_credit", credit, r.cr);
            chk("result_nickels", n_cnt, r.n);
            chk("result_dimes", d_cnt, r.d);
            chk("result_quarters", q_cnt, r.q);
          end
        end
        if (dif.dispenseValid && dif.dispenseReady) begin
          if (q_coin.size() == 0) flag("dispense");
          else chk("dispense_coin", dif.dispense, q_coin.pop_front());
        end
      end
    end
  endtask

  task automatic driver();
    int n, p, hi, seen, dv;
    model_reset();
    dif.dispenseReady = 1'b0;
    if2.dispenseReady = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_nickels", n_cnt, 5);
    chk("rst_dimes", d_cnt, 5);
    chk("rst_quarters", q_cnt, 5);
    chk("rst_credit", credit, 0);
    chk("rst_strobes", {dif.dispenseValid, dif.dispense, coin_reject, vend_ok, vend_fail}, 0);
    chk("rst_busy", busy, 0);

    // Refusal on insufficient credit shows in the cycle after the vend edge.
    vend = 1'b1; price = 8'd5; model_vend(5);
    step();
    vend = 1'b0;
    chk("short_credit_fail", vend_fail, 1);
    chk("short_credit_busy", busy, 0);
    step();
    chk("fail_pulse_width", vend_fail, 0);

    insert(2'b11); insert(2'b11);
    dif.dispenseReady = 1'b1;
    vend = 1'b1; price = 8'd35; model_vend(35);
    step();
    vend = 1'b0;
    chk("plan_busy", busy, 1);
    n = 0;
    while (!dif.dispenseValid && n < 10) begin step(); n++; end
    chk("plan_cycles", n, 3);
    chk("first_coin_dime", dif.dispense, 2'b10);
    step();
    chk("second_coin_valid", dif.dispenseValid, 1);
    chk("second_coin_nickel", dif.dispense, 2'b01);
    step();
    chk("change35_ok", vend_ok, 1);
    chk("change35_credit", credit, 0);
    chk("change35_valid_low", dif.dispenseValid, 0);
    chk("change35_counts", {n_cnt, d_cnt, q_cnt}, {8'd4, 8'd4, 8'd7});
    step();
    chk("ok_pulse_width", vend_ok, 0);

    repeat (9) insert(2'b11);
    insert(2'b10); insert(2'b01);
    chk("credit_240", credit, 240);
    insert(2'b11);
    chk("overflow_quarters", q_cnt, m_q);
    insert(2'b01);
    chk("credit_245", credit, 245);
    do_vend(245, 1'b0, 2'b00);
    chk("exact_pay_credit", credit, 0);

    insert(2'b11); insert(2'b11);
    dif.dispenseReady = 1'b0;
    vend = 1'b1; price = 8'd0; model_vend(0);
    step();
    vend = 1'b0;
    n = 0;
    while (!dif.dispenseValid && n < 10) begin step(); n++; end
    chk("stall_plan_cycles", n, 3);
    hi = q_cnt;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", dif.dispenseValid, 1);
      chk("stall_type", dif.dispense, 2'b11);
      chk("stall_quarters", q_cnt, hi);
      if (i == 1) begin
        coin_valid = 1'b1; coin_type = 2'b01; q_rej.push_back(50);
      end
      step();
      coin_valid = 1'b0; coin_type = 2'b00;
    end
    chk("stall_credit", credit, 50);
    dif.dispenseReady = 1'b1;
    step();
    dif.dispenseReady = 1'b0;
    chk("ready_edge_quarters", q_cnt, hi - 1);
    chk("mid_dispense_valid", dif.dispenseValid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", dif.dispenseValid, 0);
    chk("async_rst_counts", {n_cnt, d_cnt, q_cnt}, {8'd5, 8'd5, 8'd5});
    chk("async_rst_credit", credit, 0);
    chk("async_rst_busy", busy, 0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;

    // Second instance with no nickels or dimes: change of 5 cannot be made.
    for (int i = 0; i < 2; i++) begin
      c2_valid = 1'b1; c2_type = 2'b11; step(); c2_valid = 1'b0; c2_type = 2'b00;
    end
    chk("dut2_credit50", credit2, 50);
    c2_vend = 1'b1; c2_price = 8'd45;
    step();
    c2_vend = 1'b0;
    seen = 0; dv = 0;
    for (int i = 0; i < 10; i++) begin
      if (fail2) seen++;
      if (if2.dispenseValid) dv++;
      step();
    end
    chk("dut2_fail_cycles", seen, 1);
    chk("dut2_nothing_dispensed", dv, 0);
    chk("dut2_credit_kept", credit2, 50);
    chk("dut2_counts", {n2, d2, q2}, {8'd0, 8'd0, 8'd7});

    for (int it = 0; it < 200; it++) begin
      n = $urandom_range(0, 9);
      if (n <= 5) begin
        insert(2'($urandom_range(0, 3)));
      end else begin
        if ($urandom_range(0, 3) == 0) p = $urandom_range(0, 255);
        else p = 5 * $urandom_range(0, m_cr / 5 + 1);
        if (p > 255) p = 255;
        do_vend(p, n == 9, 2'($urandom_range(0, 3)));
      end
    end
    step(); step();
    chk("final_credit", credit, m_cr);
    chk("final_counts", {n_cnt, d_cnt, q_cnt}, {8'(m_n), 8'(m_d), 8'(m_q)});
    chk("pending_expectations", q_res.size() + q_coin.size() + q_rej.size(), 0);
  endtask

  initial begin
    fork
      driver();
      monitor();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500000");
    $fatal(1);
  end

endmodule

`default_nettype wire
